// File: rtl/model_integration_pkg.sv
// Shared types and constants for the vector integration engine.
package model_integration_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INPUT  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  localparam logic MODE_EULER     = 1'b0;
  localparam logic MODE_TRAPEZOID = 1'b1;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  // Accumulator width: full product plus two guard bits for the running sum.
  function automatic int unsigned acc_width(input int unsigned data_size);
    return 2 * data_size + 2;
  endfunction

endpackage

// File: rtl/model_vector_integration_engine_if.sv
// Control/data bus of the vector integration engine.
interface model_vector_integration_engine_if #(
  parameter int unsigned DATA_SIZE = 64
);

  logic                 START;
  logic                 READY;
  logic                 MODE_IN;
  logic                 DATA_IN_VECTOR_ENABLE;
  logic                 DATA_IN_SCALAR_ENABLE;
  logic                 DATA_OUT_VECTOR_ENABLE;
  logic                 DATA_OUT_SCALAR_ENABLE;
  logic [DATA_SIZE-1:0] SIZE_IN;
  logic [DATA_SIZE-1:0] PERIOD_IN;
  logic [DATA_SIZE-1:0] LENGTH_IN;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic [DATA_SIZE-1:0] DATA_OUT;

  modport master (
    output START, MODE_IN, DATA_IN_VECTOR_ENABLE, DATA_IN_SCALAR_ENABLE,
           SIZE_IN, PERIOD_IN, LENGTH_IN, DATA_IN,
    input  READY, DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE, DATA_OUT
  );

  modport slave (
    input  START, MODE_IN, DATA_IN_VECTOR_ENABLE, DATA_IN_SCALAR_ENABLE,
           SIZE_IN, PERIOD_IN, LENGTH_IN, DATA_IN,
    output READY, DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE, DATA_OUT
  );

endinterface

// File: rtl/model_integration_accumulator_bank.sv
// MAX_SIZE x (acc, prev) register file with one accumulate-write port and one
// registered read port. The integration step term is formed here so that the
// previous sample never has to leave the bank.
module model_integration_accumulator_bank
  import model_integration_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned MAX_SIZE  = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       wr_en_i,
  input  logic                                       wr_first_i,
  input  logic                                       mode_i,
  input  logic [IDX_W-1:0]                           wr_idx_i,
  input  logic signed [DATA_SIZE-1:0]                wr_x_i,
  input  logic signed [DATA_SIZE-1:0]                period_i,
  input  logic                                       rd_en_i,
  input  logic [IDX_W-1:0]                           rd_idx_i,
  output logic signed [acc_width(DATA_SIZE)-1:0]     rd_data_o
);

  localparam int unsigned ACC_W  = acc_width(DATA_SIZE);
  localparam int unsigned PROD_W = 2 * DATA_SIZE;
  localparam int unsigned TRAP_W = 2 * DATA_SIZE + 1;

  logic signed [ACC_W-1:0]     acc_q [MAX_SIZE];
  logic signed [DATA_SIZE-1:0] prev_q [MAX_SIZE];
  logic signed [ACC_W-1:0]     rd_data_q;

  logic signed [DATA_SIZE-1:0] prev_sel;
  logic signed [ACC_W-1:0]     acc_sel;
  logic signed [DATA_SIZE:0]   pair_sum;
  logic signed [PROD_W-1:0]    euler_prod;
  logic signed [TRAP_W-1:0]    trap_prod;
  logic signed [ACC_W-1:0]     term;
  logic signed [ACC_W-1:0]     acc_nxt;

  // Step term and next accumulator value for the element being written.
  always_comb begin
    prev_sel   = prev_q[wr_idx_i];
    acc_sel    = acc_q[wr_idx_i];
    pair_sum   = (DATA_SIZE+1)'(wr_x_i) + (DATA_SIZE+1)'(prev_sel);
    euler_prod = PROD_W'(wr_x_i) * PROD_W'(period_i);
    trap_prod  = TRAP_W'(pair_sum) * TRAP_W'(period_i);
    term       = ACC_W'(euler_prod);
    if (mode_i == MODE_TRAPEZOID) begin
      term = ACC_W'(trap_prod >>> 1);
    end
    acc_nxt = acc_sel + term;
    if (wr_first_i) begin
      acc_nxt = (mode_i == MODE_TRAPEZOID) ? '0 : term;
    end
  end

  // Bank storage and registered read port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < int'(MAX_SIZE); j++) begin
        acc_q[j]  <= '0;
        prev_q[j] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) begin
        acc_q[wr_idx_i]  <= acc_nxt;
        prev_q[wr_idx_i] <= wr_x_i;
      end
      if (rd_en_i) begin
        rd_data_q <= acc_q[rd_idx_i];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/model_vector_integration_engine.sv
// Fixed-point vector integrator: accepts LENGTH sample vectors of SIZE
// elements, integrates each element with the Euler or trapezoidal rule and
// streams the integrated vector out one element per cycle.
// Optional: MODEL_VECTOR_INTEGRATION_ENGINE_SATURATION_EN saturates the
// output conversion instead of wrapping.
module model_vector_integration_engine
  import model_integration_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned FRAC_BITS    = 32,
  parameter int unsigned MAX_SIZE     = 16
) (
  input logic                            CLK,
  input logic                            RST,
  model_vector_integration_engine_if.slave bus
);

  localparam int unsigned ACC_W = acc_width(DATA_SIZE);
  localparam int unsigned IDX_W = $clog2(MAX_SIZE);
  localparam int unsigned CNT_W = $clog2(MAX_SIZE + 1);

  if (FRAC_BITS >= DATA_SIZE || MAX_SIZE < 2 || CONTROL_SIZE == 0) begin : g_bad_params
    $error("model_vector_integration_engine: unsupported parameter set");
  end

`ifdef MODEL_VECTOR_INTEGRATION_ENGINE_SATURATION_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
`endif

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            size_q, size_d;
  logic [DATA_SIZE-1:0]        length_q, length_d;
  logic signed [DATA_SIZE-1:0] period_q, period_d;
  logic                        mode_q, mode_d;
  logic [CNT_W-1:0]            i_q, i_d;
  logic [DATA_SIZE-1:0]        k_q, k_d;
  logic [CNT_W-1:0]            rd_cnt_q, rd_cnt_d;
  logic                        rd_vld_q, rd_vld_d;
  logic                        rd_first_q, rd_first_d;
  logic                        rd_last_q, rd_last_d;
  logic                        out_last_q, out_last_d;
  logic                        ready_q, ready_d;
  logic                        vec_en_q, vec_en_d;
  logic                        sc_en_q, sc_en_d;
  logic [DATA_SIZE-1:0]        data_out_q, data_out_d;

  logic                        wr_en_c;
  logic                        wr_first_c;
  logic                        rd_en_c;
  logic [IDX_W-1:0]            wr_idx_c;
  logic [IDX_W-1:0]            rd_idx_c;
  logic signed [ACC_W-1:0]     rd_data;
  logic signed [ACC_W-1:0]     acc_shift;
  logic [DATA_SIZE-1:0]        conv_c;

  assign wr_idx_c = IDX_W'(i_q);
  assign rd_idx_c = IDX_W'(rd_cnt_q);

  model_integration_accumulator_bank #(
    .DATA_SIZE (DATA_SIZE),
    .MAX_SIZE  (MAX_SIZE),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .wr_en_i    (wr_en_c),
    .wr_first_i (wr_first_c),
    .mode_i     (mode_q),
    .wr_idx_i   (wr_idx_c),
    .wr_x_i     (bus.DATA_IN),
    .period_i   (period_q),
    .rd_en_i    (rd_en_c),
    .rd_idx_i   (rd_idx_c),
    .rd_data_o  (rd_data)
  );

  // Drop the fraction bits and fit the result into DATA_SIZE.
  always_comb begin
    acc_shift = rd_data >>> FRAC_BITS;
`ifdef MODEL_VECTOR_INTEGRATION_ENGINE_SATURATION_EN
    if (acc_shift > SAT_MAX) begin
      conv_c = DATA_SIZE'(SAT_MAX);
    end else if (acc_shift < SAT_MIN) begin
      conv_c = DATA_SIZE'(SAT_MIN);
    end else begin
      conv_c = DATA_SIZE'(acc_shift);
    end
`else
    conv_c = DATA_SIZE'(acc_shift);
`endif
  end

  // Next-state, counters, bank control and output staging.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    length_d   = length_q;
    period_d   = period_q;
    mode_d     = mode_q;
    i_d        = i_q;
    k_d        = k_q;
    rd_cnt_d   = rd_cnt_q;
    rd_vld_d   = ZERO;
    rd_first_d = ZERO;
    rd_last_d  = ZERO;
    out_last_d = ZERO;
    ready_d    = ZERO;
    vec_en_d   = ZERO;
    sc_en_d    = ZERO;
    data_out_d = data_out_q;
    wr_en_c    = ZERO;
    wr_first_c = ZERO;
    rd_en_c    = ZERO;

    case (state_q)
      IDLE: begin
        // A START overlapping the completion pulse must be reasserted.
        if (bus.START && !ready_q) begin
          size_d   = CNT_W'(bus.SIZE_IN);
          length_d = bus.LENGTH_IN;
          period_d = bus.PERIOD_IN;
          mode_d   = bus.MODE_IN;
          i_d      = '0;
          k_d      = '0;
          if (bus.SIZE_IN == '0 || bus.LENGTH_IN == '0 ||
              bus.SIZE_IN > DATA_SIZE'(MAX_SIZE)) begin
            ready_d = ONE;
          end else begin
            state_d = INPUT;
          end
        end
      end

      INPUT: begin
        if (bus.DATA_IN_SCALAR_ENABLE) begin
          wr_en_c    = ONE;
          wr_first_c = (k_q == '0);
          if (i_q == size_q - CNT_W'(1)) begin
            i_d = '0;
            if (k_q == length_q - DATA_SIZE'(1)) begin
              state_d  = OUTPUT;
              rd_cnt_d = '0;
            end else begin
              k_d = k_q + DATA_SIZE'(1);
            end
          end else begin
            i_d = i_q + CNT_W'(1);
          end
        end
      end

      OUTPUT: begin
        if (rd_cnt_q < size_q) begin
          rd_en_c    = ONE;
          rd_cnt_d   = rd_cnt_q + CNT_W'(1);
          rd_vld_d   = ONE;
          rd_first_d = (rd_cnt_q == '0);
          rd_last_d  = (rd_cnt_q == size_q - CNT_W'(1));
        end
        if (rd_vld_q) begin
          data_out_d = conv_c;
          sc_en_d    = ONE;
          vec_en_d   = rd_first_q;
          out_last_d = rd_last_q;
        end
        if (out_last_q) begin
          ready_d = ONE;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      size_q     <= '0;
      length_q   <= '0;
      period_q   <= '0;
      mode_q     <= MODE_EULER;
      i_q        <= '0;
      k_q        <= '0;
      rd_cnt_q   <= '0;
      rd_vld_q   <= ZERO;
      rd_first_q <= ZERO;
      rd_last_q  <= ZERO;
      out_last_q <= ZERO;
      ready_q    <= ZERO;
      vec_en_q   <= ZERO;
      sc_en_q    <= ZERO;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      length_q   <= length_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      i_q        <= i_d;
      k_q        <= k_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_first_q <= rd_first_d;
      rd_last_q  <= rd_last_d;
      out_last_q <= out_last_d;
      ready_q    <= ready_d;
      vec_en_q   <= vec_en_d;
      sc_en_q    <= sc_en_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.READY                  = ready_q;
  assign bus.DATA_OUT_VECTOR_ENABLE = vec_en_q;
  assign bus.DATA_OUT_SCALAR_ENABLE = sc_en_q;
  assign bus.DATA_OUT               = data_out_q;

endmodule

// File: tb/tb_model_vector_integration_engine.sv
// Scoreboard bench for model_vector_integration_engine at DATA_SIZE=16,
// FRAC_BITS=8, MAX_SIZE=4 (1.0 = 0x0100).
module tb_model_vector_integration_engine;

  localparam int unsigned DS = 16;
  localparam int unsigned FB = 8;
  localparam int unsigned MS = 4;

  typedef struct {
    logic [DS-1:0] data;
    logic          vec;
    logic          last;
    int            exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ready_cnt = 0;
  logic pend_ready = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;

  model_vector_integration_engine_if #(.DATA_SIZE(DS)) bus ();

  model_vector_integration_engine #(
    .DATA_SIZE    (DS),
    .CONTROL_SIZE (DS),
    .FRAC_BITS    (FB),
    .MAX_SIZE     (MS)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pop expected element whenever the DUT presents one.
  always @(negedge clk) begin
    if (pend_ready) check("ready_after_last", {31'd0, bus.READY}, 32'd1);
    pend_ready = 1'b0;
    if (bus.READY === 1'b1) ready_cnt++;
    if (bus.DATA_OUT_VECTOR_ENABLE === 1'b1 && bus.DATA_OUT_SCALAR_ENABLE !== 1'b1)
      check("vec_without_scalar", {31'd0, bus.DATA_OUT_VECTOR_ENABLE}, 32'd0);
    if (bus.DATA_OUT_SCALAR_ENABLE === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {31'd0, bus.DATA_OUT_SCALAR_ENABLE}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_data", {16'd0, bus.DATA_OUT}, {16'd0, mon_e.data});
        check("out_vec_enable", {31'd0, bus.DATA_OUT_VECTOR_ENABLE}, {31'd0, mon_e.vec});
        if (mon_e.exp_cyc >= 0) check("first_latency", cyc, mon_e.exp_cyc);
        pend_ready = mon_e.last;
      end
    end
  end

  task automatic idle_inputs();
    bus.START = 1'b0;
    bus.MODE_IN = 1'b0;
    bus.DATA_IN_VECTOR_ENABLE = 1'b0;
    bus.DATA_IN_SCALAR_ENABLE = 1'b0;
    bus.DATA_IN = '0;
  endtask

  task automatic start_run(input logic [DS-1:0] size, input logic [DS-1:0] len,
                           input logic [DS-1:0] period, input logic mode);
    bus.SIZE_IN = size;
    bus.LENGTH_IN = len;
    bus.PERIOD_IN = period;
    bus.MODE_IN = mode;
    bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
  endtask

  // Stream samples; optional idle gaps carry junk and a stray START.
  task automatic send(input int size, input int len, input logic [DS-1:0] xs [4],
                      input bit gaps, output int last_cyc);
    last_cyc = cyc;
    for (int k = 0; k < len; k++) begin
      for (int i = 0; i < size; i++) begin
        bus.DATA_IN_SCALAR_ENABLE = 1'b1;
        bus.DATA_IN_VECTOR_ENABLE = (i == 0);
        bus.DATA_IN = xs[i];
        last_cyc = cyc;
        @(posedge clk); #1;
        if (gaps && ((k + i) % 2 == 0) && !(k == len - 1 && i == size - 1)) begin
          bus.DATA_IN_SCALAR_ENABLE = 1'b0;
          bus.DATA_IN_VECTOR_ENABLE = 1'b1;
          bus.DATA_IN = 16'hDEAD;
          bus.START = (k == 1);
          bus.MODE_IN = 1'b1;
          bus.SIZE_IN = 16'd1;
          repeat ((k == 2) ? 2 : 1) begin
            @(posedge clk); #1;
            bus.START = 1'b0;
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, sb_q.size(), 32'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string name, input int size, input int len,
                          input logic [DS-1:0] period, input logic mode,
                          input logic [DS-1:0] xs [4], input logic [DS-1:0] ex [4],
                          input bit gaps);
    int lc;
    int r0;
    exp_t e;
    r0 = ready_cnt;
    start_run(DS'(size), DS'(len), period, mode);
    send(size, len, xs, gaps, lc);
    for (int i = 0; i < size; i++) begin
      e.data = ex[i];
      e.vec = (i == 0);
      e.last = (i == size - 1);
      e.exp_cyc = (i == 0) ? lc + 3 : -1;
      sb_q.push_back(e);
    end
    drain(name);
    check({name, "_ready_count"}, ready_cnt - r0, 32'd1);
  endtask

  // Invalid configuration: READY next cycle, START held over READY is ignored.
  task automatic degenerate(input string name, input logic [DS-1:0] size, input logic [DS-1:0] len);
    int r0;
    r0 = ready_cnt;
    bus.SIZE_IN = size;
    bus.LENGTH_IN = len;
    bus.PERIOD_IN = 16'h0100;
    bus.START = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_ready"}, {31'd0, bus.READY}, 32'd1);
    check({name, "_no_scalar"}, {31'd0, bus.DATA_OUT_SCALAR_ENABLE}, 32'd0);
    check({name, "_no_vector"}, {31'd0, bus.DATA_OUT_VECTOR_ENABLE}, 32'd0);
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({name, "_ready_count"}, ready_cnt - r0, 32'd1);
  endtask

  initial begin
    logic [DS-1:0] xs [4];
    logic [DS-1:0] ex [4];
    int r0;

    idle_inputs();
    bus.SIZE_IN = '0;
    bus.LENGTH_IN = '0;
    bus.PERIOD_IN = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_ready", {31'd0, bus.READY}, 32'd0);
    check("reset_scalar", {31'd0, bus.DATA_OUT_SCALAR_ENABLE}, 32'd0);
    check("reset_vector", {31'd0, bus.DATA_OUT_VECTOR_ENABLE}, 32'd0);
    check("reset_data", {16'd0, bus.DATA_OUT}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xs = '{16'h0100, 16'h0200, 16'h0000, 16'h0000};
    ex = '{16'h0180, 16'h0300, 16'h0000, 16'h0000};
    run_case("euler", 2, 3, 16'h0080, 1'b0, xs, ex, 1'b0);

    ex = '{16'h0100, 16'h0200, 16'h0000, 16'h0000};
    run_case("trapezoid", 2, 3, 16'h0080, 1'b1, xs, ex, 1'b0);

    xs = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
`ifdef MODEL_VECTOR_INTEGRATION_ENGINE_SATURATION_EN
    ex = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
`else
    ex = '{16'hFC00, 16'h0000, 16'h0000, 16'h0000};
`endif
    run_case("overflow", 1, 4, 16'h7FFF, 1'b0, xs, ex, 1'b0);

    degenerate("size0", 16'd0, 16'd3);
    degenerate("size5", 16'd5, 16'd3);
    degenerate("length0", 16'd2, 16'd0);

    xs = '{16'h0100, 16'h0200, 16'h0000, 16'h0000};
    ex = '{16'h0180, 16'h0300, 16'h0000, 16'h0000};
    run_case("euler_gaps", 2, 3, 16'h0080, 1'b0, xs, ex, 1'b1);

    // Abort mid-INPUT; no READY may follow for this run.
    r0 = ready_cnt;
    start_run(16'd2, 16'd3, 16'h0080, 1'b0);
    bus.DATA_IN_SCALAR_ENABLE = 1'b1;
    bus.DATA_IN_VECTOR_ENABLE = 1'b1;
    bus.DATA_IN = 16'h0100;
    @(posedge clk); #1;
    bus.DATA_IN_VECTOR_ENABLE = 1'b0;
    bus.DATA_IN = 16'h0200;
    @(posedge clk); #1;
    bus.DATA_IN_VECTOR_ENABLE = 1'b1;
    bus.DATA_IN = 16'h0100;
    @(posedge clk); #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("abort_ready", {31'd0, bus.READY}, 32'd0);
    check("abort_scalar", {31'd0, bus.DATA_OUT_SCALAR_ENABLE}, 32'd0);
    check("abort_vector", {31'd0, bus.DATA_OUT_VECTOR_ENABLE}, 32'd0);
    check("abort_data", {16'd0, bus.DATA_OUT}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_ready", ready_cnt - r0, 32'd0);

    ex = '{16'h0180, 16'h0300, 16'h0000, 16'h0000};
    run_case("euler_after_reset", 2, 3, 16'h0080, 1'b0, xs, ex, 1'b0);

    ex = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_case("trapezoid_len1", 2, 1, 16'h0080, 1'b1, xs, ex, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/model_vector_integration_engine.md
Name: model_vector_integration_engine

Overview:
Parametrised fixed-point vector integrator for the NTM math/calculus library.
- Input: LENGTH_IN sample vectors of SIZE_IN elements, streamed sample-major.
- Per element: integrates over the samples with step PERIOD_IN, using Euler (rectangle) or trapezoidal rule selected at START.
- Output: the integrated vector, streamed one element per cycle.
- Replaces the unimplemented float-based vector integrator with a complete FSM, a runtime mode, and a MAX_SIZE-deep accumulator bank.

Parameters:
DATA_SIZE, 64, width of data/size/period/length words; signed two's complement Q(DATA_SIZE-FRAC_BITS).FRAC_BITS
CONTROL_SIZE, 64, kept for library-wide interface uniformity; unused internally
FRAC_BITS, 32, fractional bits of DATA_IN, PERIOD_IN, DATA_OUT
MAX_SIZE, 16, accumulator bank depth (maximum vector length)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
START  in  1  begin operation; sampled only in IDLE
READY  out  1  one-cycle pulse at completion
MODE_IN  in  1  0 = Euler, 1 = trapezoidal; latched at START
DATA_IN_VECTOR_ENABLE  in  1  marks element 0 of each input sample vector
DATA_IN_SCALAR_ENABLE  in  1  DATA_IN element valid this cycle
DATA_OUT_VECTOR_ENABLE  out  1  marks element 0 of output vector
DATA_OUT_SCALAR_ENABLE  out  1  DATA_OUT element valid this cycle
SIZE_IN  in  DATA_SIZE  elements per vector; latched at START
PERIOD_IN  in  DATA_SIZE  step h, fixed-point; latched at START
LENGTH_IN  in  DATA_SIZE  samples per element; latched at START
DATA_IN  in  DATA_SIZE  input element
DATA_OUT  out  DATA_SIZE  integrated element

Behaviour:
- Reset (RST low, async): state IDLE; READY, both OUT enables = 0; DATA_OUT = 0; counters cleared. Accumulator contents need not be cleared.
- States: IDLE -> INPUT -> OUTPUT -> IDLE.
- IDLE:
  - START=1 latches SIZE, PERIOD, LENGTH, MODE; clears i (element index) and k (sample index); goes to INPUT.
  - If SIZE_IN==0, LENGTH_IN==0 or SIZE_IN>MAX_SIZE: no INPUT/OUTPUT; READY pulses the next cycle.
- INPUT:
  - An element is accepted only when DATA_IN_SCALAR_ENABLE=1; every cycle is acceptable, so there is no backpressure.
  - DATA_IN_VECTOR_ENABLE is informational; the counters alone define position.
  - Euler, per accepted x at index i: term = x*PERIOD (2*DATA_SIZE signed). k==0: acc[i]=term; else acc[i]+=term.
  - Trapezoid: k==0: acc[i]=0, prev[i]=x. k>=1: term = ((x+prev[i]) sign-extended to DATA_SIZE+1, times PERIOD) >>> 1; acc[i]+=term; prev[i]=x.
  - Accumulator width is 2*DATA_SIZE+2 and wraps modulo.
  - i wraps SIZE-1 -> 0 and increments k.
  - Acceptance of element (SIZE-1, LENGTH-1) moves to OUTPUT.
- OUTPUT:
  - First output comes 2 cycles after the last accepted input (bank read is registered).
  - Then one element per cycle, i = 0..SIZE-1: DATA_OUT = (acc[i] >>> FRAC_BITS) truncated to DATA_SIZE.
  - DATA_OUT_SCALAR_ENABLE=1 on each element; DATA_OUT_VECTOR_ENABLE=1 only with i=0.
  - READY pulses in the cycle after the last element; return to IDLE.
  - Enables drop to 0 outside OUTPUT; DATA_OUT holds its last value.
- Boundary cases:
  - START outside IDLE is ignored.
  - Input enables are ignored outside INPUT.
  - Trapezoid with LENGTH==1 outputs zeros.
  - Reset mid-operation aborts with no READY.
  - START in the same cycle as READY is ignored; it must be reasserted.

Optional Feature:
MODEL_VECTOR_INTEGRATION_ENGINE_SATURATION_EN
- Defined: output conversion saturates; result > max gives 2^(DATA_SIZE-1)-1, result < min gives -2^(DATA_SIZE-1).
- Undefined: plain truncation (wrap).
- The accumulator wraps in both cases.

Decomposition:
- Package model_integration_pkg holds:
  - state enum (IDLE, INPUT, OUTPUT)
  - MODE_EULER=0, MODE_TRAPEZOID=1
  - ZERO/ONE constants
  - function for accumulator width
- Sub-module model_integration_accumulator_bank: MAX_SIZE x (acc, prev) register file.
  - Write: one per cycle, write/accumulate select.
  - Read: one registered port.
  - Reset: async active-low.

Test Plan (DATA_SIZE=16, FRAC_BITS=8, MAX_SIZE=4, 1.0=0x0100):
- Euler: SIZE=2, LENGTH=3, PERIOD=0x0080, three samples [0x0100,0x0200] on back-to-back cycles -> outputs 0x0180, 0x0300 with VECTOR_ENABLE on first only; READY one cycle after second.
- Trapezoid, same stimulus -> outputs 0x0100, 0x0200.
- SIZE=1, LENGTH=4, PERIOD=0x7FFF, x=0x7FFF, Euler -> 0xFC00 without macro; 0x7FFF with the SATURATION_EN macro.
- SIZE=0 or SIZE=5 with START -> READY next cycle, no OUT enables asserted.
- Gaps in DATA_IN_SCALAR_ENABLE, plus START pulsed during INPUT -> results identical to the Euler case and the START is ignored.
- RST low during INPUT, then a fresh Euler run -> all outputs 0 during reset, no READY for the aborted run, new results correct.
